// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register used between
// the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
package pipe_pkg;

  // The encoding doubles as the occupancy count reported on occ_o.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stageState_e;

  localparam int DATA_W_DEF = 69;
  localparam int CTRL_W_DEF = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage: a main register drives the outputs and
// a skid register absorbs one entry so in_ready_o can be fully registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  stageState_e       state_p0;
  stageState_e       stateNext;
  logic              inRdy_p0;
  logic              vld_p0;
  logic [CTRL_W-1:0] mainCtrl_p0;
  logic [DATA_W-1:0] mainData_p0;
  logic [CTRL_W-1:0] skidCtrl_p1;
  logic [DATA_W-1:0] skidData_p1;

  logic inFire;
  logic outFire;
  logic loadMainIn;
  logic loadMainSkid;
  logic loadSkid;
  logic clrCtrl;

  assign vld_p0  = (state_p0 != EMPTY);
  assign inFire  = in_valid_i & inRdy_p0;
  assign outFire = vld_p0 & out_ready_i;

  always_comb begin
    stateNext    = state_p0;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    clrCtrl      = 1'b0;
    if (flush_i) begin
      // Flush wins over everything, including an input firing this cycle.
      stateNext = EMPTY;
      clrCtrl   = 1'b1;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (inFire) begin
            loadMainIn = 1'b1;
            stateNext  = ONE;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            loadMainIn = 1'b1;
          end else if (inFire) begin
            loadSkid  = 1'b1;
            stateNext = TWO;
          end else if (outFire) begin
            clrCtrl   = 1'b1;
            stateNext = EMPTY;
          end
        end
        TWO: begin
          if (outFire) begin
            loadMainSkid = 1'b1;
            stateNext    = ONE;
          end
        end
        default: begin
          clrCtrl   = 1'b1;
          stateNext = EMPTY;
        end
      endcase
    end
  end

  // ---- stage p0 (main) / p1 (skid) registers ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_p0    <= EMPTY;
      inRdy_p0    <= 1'b1;
      mainCtrl_p0 <= '0;
      mainData_p0 <= '0;
      skidCtrl_p1 <= '0;
      skidData_p1 <= '0;
    end else begin
      state_p0 <= stateNext;
      inRdy_p0 <= (stateNext != TWO);
      if (loadMainIn) begin
        mainCtrl_p0 <= ctrl_i;
        mainData_p0 <= data_i;
      end else if (loadMainSkid) begin
        mainCtrl_p0 <= skidCtrl_p1;
        mainData_p0 <= skidData_p1;
      end else if (clrCtrl) begin
        // Data is left as-is so data_o keeps its last value while idle.
        mainCtrl_p0 <= '0;
      end
      if (loadSkid) begin
        skidCtrl_p1 <= ctrl_i;
        skidData_p1 <= data_i;
      end
    end
  end

  assign in_ready_o  = inRdy_p0;
  assign out_valid_o = vld_p0;
  assign ctrl_o      = mainCtrl_p0;
  assign data_o      = mainData_p0;
  assign occ_o       = state_p0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg against a FIFO queue model.
module tb_pipe_stage_reg;

  localparam int DW = 69;
  localparam int CW = 2;

  logic          clk_i;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [1:0]    occ_o;

  int checks   = 0;
  int failures = 0;

  logic [CW+DW-1:0] modelQ[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .occ_o       (occ_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic rdy, input logic fl);
    in_valid_i  = v;
    ctrl_i      = c;
    data_i      = d;
    out_ready_i = rdy;
    flush_i     = fl;
  endtask

  task automatic chkOut(input string tag, input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic [1:0] o, input logic r);
    chk({tag, ".vld"},  80'(out_valid_o), 80'(v));
    chk({tag, ".ctrl"}, 80'(ctrl_o),      80'(c));
    chk({tag, ".data"}, 80'(data_o),      80'(d));
    chk({tag, ".occ"},  80'(occ_o),       80'(o));
    chk({tag, ".rdy"},  80'(in_ready_o),  80'(r));
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1 chkOut("reset", 1'b0, 2'b00, '0, 2'd0, 1'b1);
    tick();
    tick();

    // First entry after reset release: latency one cycle.
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b1, 2'b11, 69'h1234, 1'b1, 1'b0);
    tick();
    chkOut("first", 1'b1, 2'b11, 69'h1234, 2'd1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chkOut("drain1", 1'b0, 2'b00, 69'h1234, 2'd0, 1'b1);

    // Back-to-back stream of 8 entries.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
      tick();
      chkOut($sformatf("stream%0d", i), 1'b1, CW'(i), DW'(i), 2'd1, 1'b1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chkOut("streamEnd", 1'b0, 2'b00, 69'h8, 2'd0, 1'b1);

    // Stall: fill main and skid, hold a third entry, then drain in order.
    drive(1'b1, 2'b01, 69'hA, 1'b0, 1'b0);
    tick();
    chkOut("stallA", 1'b1, 2'b01, 69'hA, 2'd1, 1'b1);
    drive(1'b1, 2'b10, 69'hB, 1'b0, 1'b0);
    tick();
    chkOut("stallB", 1'b1, 2'b01, 69'hA, 2'd2, 1'b0);
    drive(1'b1, 2'b11, 69'hC, 1'b0, 1'b0);
    tick();
    chkOut("stallHold", 1'b1, 2'b01, 69'hA, 2'd2, 1'b0);
    drive(1'b1, 2'b11, 69'hC, 1'b1, 1'b0);
    tick();
    chkOut("drainB", 1'b1, 2'b10, 69'hB, 2'd1, 1'b1);
    tick();
    chkOut("drainC", 1'b1, 2'b11, 69'hC, 2'd1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chkOut("drainEnd", 1'b0, 2'b00, 69'hC, 2'd0, 1'b1);

    // Flush while full, with a pending input.
    drive(1'b1, 2'b01, 69'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 69'h22, 1'b0, 1'b0);
    tick();
    chk("flushFull.occ", 80'(occ_o), 80'(2));
    drive(1'b1, 2'b11, 69'hD, 1'b0, 1'b1);
    tick();
    chkOut("flushFull", 1'b0, 2'b00, 69'h11, 2'd0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chkOut("flushFullAfter", 1'b0, 2'b00, 69'h11, 2'd0, 1'b1);

    // Flush in ONE while an input would fire: the input is discarded.
    drive(1'b1, 2'b01, 69'h33, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b11, 69'hDD, 1'b1, 1'b1);
    tick();
    chkOut("flushOne", 1'b0, 2'b00, 69'h33, 2'd0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chkOut("flushOneAfter", 1'b0, 2'b00, 69'h33, 2'd0, 1'b1);

    // Asynchronous reset mid-cycle while full.
    drive(1'b1, 2'b01, 69'h66, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 69'h77, 1'b0, 1'b0);
    tick();
    chk("preRst.occ", 80'(occ_o), 80'(2));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_i = 1'b0;
    #1 chkOut("asyncRst", 1'b0, 2'b00, '0, 2'd0, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b1, 2'b10, 69'h55, 1'b1, 1'b0);
    tick();
    chkOut("postRst", 1'b1, 2'b10, 69'h55, 2'd1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chkOut("postRstEnd", 1'b0, 2'b00, 69'h55, 2'd0, 1'b1);

    // Randomized traffic against a queue model.
    modelQ.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic          v;
      logic          r;
      logic          f;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic          inF;
      logic          outF;
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) != 0);
      f = 1'($urandom_range(0, 63) == 0);
      c = CW'($urandom);
      d = {5'($urandom), $urandom, $urandom};
      drive(v, c, d, r, f);
      inF  = v && (modelQ.size() < 2);
      outF = r && (modelQ.size() != 0);
      tick();
      if (f) begin
        modelQ.delete();
      end else begin
        if (outF) void'(modelQ.pop_front());
        if (inF) modelQ.push_back({c, d});
      end
      chk("rnd.vld", 80'(out_valid_o), 80'(modelQ.size() != 0));
      chk("rnd.occ", 80'(occ_o),       80'(modelQ.size()));
      chk("rnd.rdy", 80'(in_ready_o),  80'(modelQ.size() < 2));
      if (modelQ.size() != 0)
        chk("rnd.entry", 80'({ctrl_o, data_o}), 80'(modelQ[0]));
      else
        chk("rnd.ctrl0", 80'(ctrl_o), 80'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
